// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command codes, sequencer states and the config-byte lookup shared by the LCD driver
package lcd_pkg;
  localparam logic [7:0] LCD_FUNC_SET = 8'h28;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1    = 8'h80;
  localparam logic [7:0] LCD_LINE2    = 8'hC0;
  typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, ADDR1, LINE1, ADDR2, LINE2} lcd_state_t;
  function automatic logic [7:0] cfg_byte(input logic [1:0] step);
    return step == 2'd0 ? LCD_FUNC_SET : step == 2'd1 ? LCD_ENTRY : step == 2'd2 ? LCD_DISP_ON : LCD_CLEAR;
  endfunction
endpackage

// File: rtl/lcd_nibble_writer.sv
// lcd_nibble_writer: one nibble strobe (setup, E high, hold, wait); in start/rs/nib/wait_cycles, out done (one cycle before the period ends) and registered pins lcd_e/lcd_rs/lcd_dat
module lcd_nibble_writer #(
  parameter int T_SU = 2,
  parameter int T_EH = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rs,
  input  logic [3:0]  nib,
  input  logic [31:0] wait_cycles,
  output logic        done,
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic [3:0]  lcd_dat
);
  // at least one setup and one E-high cycle so E never rises with a data change
  localparam logic [31:0] SU = T_SU < 1 ? 32'd1 : 32'(T_SU);
  localparam logic [31:0] EH = T_EH < 1 ? 32'd1 : 32'(T_EH);
  logic busy, load, nbusy;
  logic [31:0] cnt, lim, ncnt, nlim;
  // a new nibble may be accepted in the final cycle of the current one, so periods chain with no gap
  always_comb begin
    load = start && (!busy || cnt == lim);
    nbusy = load || (busy && cnt != lim);
    ncnt = load ? '0 : cnt + 32'd1;
    nlim = load ? SU + EH + wait_cycles : lim;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt <= '0;
      lim <= '0;
      done <= 1'b0;
      lcd_e <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_dat <= '0;
    end else begin
      busy <= nbusy;
      cnt <= nbusy ? ncnt : cnt;
      lim <= nlim;
      // done leads the last cycle by one so the sequencer's registered start lands on it
      done <= nbusy && ncnt + 32'd1 == nlim;
      lcd_e <= nbusy && ncnt >= SU && ncnt < SU + EH;
      if (load) begin
        lcd_rs <= rs;
        lcd_dat <= nib;
      end
    end
  end
endmodule

// File: rtl/lcd_string_driver.sv
// lcd_string_driver: HD44780 4-bit init + continuous two-line refresh of a 32-char snapshot; in CCLK/RSTN/strdata, out LCDE/LCDRS/LCDRW/LCDDAT/init_done/frame_done
module lcd_string_driver
  import lcd_pkg::*;
#(
  parameter int T_PWR   = 750000,
  parameter int T_4MS   = 205000,
  parameter int T_100US = 5000,
  parameter int T_40US  = 2000,
  parameter int T_CLR   = 82000,
  parameter int T_1US   = 50,
  parameter int T_SU    = 2,
  parameter int T_EH    = 12
) (
  input  logic         CCLK,
  input  logic         RSTN,
  input  logic [255:0] strdata,
  output logic         LCDE,
  output logic         LCDRS,
  output logic         LCDRW,
  output logic [3:0]   LCDDAT,
  output logic         init_done,
  output logic         frame_done
);
  localparam logic [31:0] W_PWR = 32'(T_PWR);
  localparam logic [31:0] W_4MS = 32'(T_4MS);
  localparam logic [31:0] W_100 = 32'(T_100US);
  localparam logic [31:0] W_40  = 32'(T_40US);
  localparam logic [31:0] W_CLR = 32'(T_CLR);
  localparam logic [31:0] W_1US = 32'(T_1US);
  lcd_state_t state;
  logic [31:0] pcnt, wr_wait, req_wait;
  logic [1:0] step;
  logic [4:0] idx;
  logic [255:0] snap;
  logic [7:0] cur;
  logic [3:0] wr_nib, req_nib;
  logic lo, kick, start, wr_rs, req_rs, done, go;
  assign LCDRW = 1'b0;
  // state/step/lo/idx point at the next nibble to hand to the writer
  always_comb begin
    cur = state == CFG ? cfg_byte(step) : state == ADDR1 ? LCD_LINE1 : state == ADDR2 ? LCD_LINE2 : snap[{~idx, 3'b111} -: 8];
    req_rs = state == LINE1 || state == LINE2;
    req_nib = state == INIT ? (step == 2'd3 ? 4'h2 : 4'h3) : lo ? cur[3:0] : cur[7:4];
    req_wait = state == INIT ? (step == 2'd0 ? W_4MS : step == 2'd1 ? W_100 : W_40)
             : !lo ? W_1US : (state == CFG && step == 2'd3) ? W_CLR : W_40;
    go = kick || done;
  end
  always_ff @(posedge CCLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= PWR_WAIT;
      pcnt <= '0;
      step <= '0;
      idx <= '0;
      lo <= 1'b0;
      kick <= 1'b0;
      start <= 1'b0;
      wr_rs <= 1'b0;
      wr_nib <= '0;
      wr_wait <= '0;
      snap <= '0;
      init_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      start <= go;
      kick <= 1'b0;
      // start with the ADDR1 high nibble marks the first cycle after the previous wait ended
      frame_done <= start && state == ADDR1 && lo && init_done;
      if (start && state == ADDR1 && lo) init_done <= 1'b1;
      if (state == PWR_WAIT) begin
        if (pcnt >= W_PWR) begin
          state <= INIT;
          kick <= 1'b1;
        end else pcnt <= pcnt + 32'd1;
      end else if (go) begin
        wr_rs <= req_rs;
        wr_nib <= req_nib;
        wr_wait <= req_wait;
        if (state == INIT) begin
          step <= step + 2'd1;
          if (step == 2'd3) state <= CFG;
        end else begin
          lo <= ~lo;
          if (lo) begin
            case (state)
              CFG: begin
                step <= step + 2'd1;
                if (step == 2'd3) begin
                  state <= ADDR1;
                  snap <= strdata;
                end
              end
              ADDR1: state <= LINE1;
              LINE1: begin
                idx <= idx + 5'd1;
                if (idx == 5'd15) state <= ADDR2;
              end
              ADDR2: state <= LINE2;
              LINE2: begin
                idx <= idx + 5'd1;
                if (idx == 5'd31) begin
                  state <= ADDR1;
                  snap <= strdata;
                end
              end
              default: ;
            endcase
          end
        end
      end
    end
  end
  lcd_nibble_writer #(.T_SU(T_SU), .T_EH(T_EH)) u_writer (
    .clk(CCLK),
    .rst_n(RSTN),
    .start(start),
    .rs(wr_rs),
    .nib(wr_nib),
    .wait_cycles(wr_wait),
    .done(done),
    .lcd_e(LCDE),
    .lcd_rs(LCDRS),
    .lcd_dat(LCDDAT)
  );
endmodule

// File: tb/tb_lcd_string_driver.sv
// tb_lcd_string_driver: directed bus-monitor bench for lcd_string_driver with small timing parameters
module tb_lcd_string_driver;
  localparam logic [255:0] S1 = {"Hello, LCD test!", "Pipeline CPU ok", 8'h00};
  localparam logic [255:0] S2 = {"Second string #2", "abcdefghijklmno", 8'hFF};
  logic CCLK = 1'b0;
  logic RSTN = 1'b1;
  logic [255:0] strdata = S1;
  logic LCDE, LCDRS, LCDRW, init_done, frame_done;
  logic [3:0] LCDDAT;
  always #5 CCLK = ~CCLK;
  lcd_string_driver #(
    .T_PWR(20), .T_4MS(10), .T_100US(6), .T_40US(4), .T_CLR(8), .T_1US(2), .T_SU(1), .T_EH(3)
  ) dut (
    .CCLK(CCLK), .RSTN(RSTN), .strdata(strdata), .LCDE(LCDE), .LCDRS(LCDRS),
    .LCDRW(LCDRW), .LCDDAT(LCDDAT), .init_done(init_done), .frame_done(frame_done)
  );
  typedef struct {logic rs; logic [3:0] nib; int t;} nib_t;
  typedef struct {string name; logic single; logic rs; logic [7:0] val; int gap;} vec_t;
  nib_t nq[$];
  vec_t tab[9];
  int checks = 0, errors = 0, cyc = 0, fd_cnt = 0, run = 0, last_t = 0;
  logic pe = 1'b0, prs = 1'b0, pfd = 1'b0;
  logic [3:0] pdat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // bus monitor and protocol checker, sampled on the inactive edge
  always @(negedge CCLK) begin
    cyc++;
    if (!RSTN) begin
      pe = 1'b0; prs = 1'b0; pdat = '0; pfd = 1'b0; run = 0;
    end else begin
      chk("lcdrw_zero", LCDRW, 0);
      chk("bus_stable_while_e", LCDE && (LCDDAT !== pdat || LCDRS !== prs), 0);
      chk("frame_done_width", frame_done && pfd, 0);
      if (LCDE) run++;
      else begin
        if (pe) chk("e_high_width", run, 3);
        run = 0;
      end
      if (LCDE && !pe) nq.push_back('{LCDRS, LCDDAT, cyc});
      if (frame_done && !pfd) fd_cnt++;
      pe = LCDE; prs = LCDRS; pdat = LCDDAT; pfd = frame_done;
    end
  end

  task automatic get_nibble(output nib_t n);
    int k = 0;
    while (nq.size() == 0 && k < 400) begin
      @(negedge CCLK);
      k++;
    end
    if (nq.size() == 0) begin
      chk("nibble_timeout", 1, 0);
      n = '{1'b0, 4'h0, 0};
    end else n = nq.pop_front();
  endtask

  task automatic get_byte(output logic rs, output logic [7:0] b, output int t);
    nib_t h, l;
    get_nibble(h);
    get_nibble(l);
    chk("hi_lo_nibble_gap", 32'(l.t - h.t), 7);
    rs = h.rs;
    b = {h.nib, l.nib};
    t = h.t;
  endtask

  task automatic quiet_after_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge CCLK);
      chk($sformatf("pwr_quiet_%0d", i), {LCDE, LCDRS, LCDDAT, init_done}, 0);
    end
  endtask

  task automatic run_init();
    nib_t n;
    logic rs;
    logic [7:0] b;
    int t = 0, pt = 0;
    for (int i = 0; i < 9; i++) begin
      if (tab[i].single) begin
        get_nibble(n);
        rs = n.rs; b = {4'h0, n.nib}; t = n.t;
      end else get_byte(rs, b, t);
      chk({tab[i].name, "_rs"}, rs, tab[i].rs);
      chk({tab[i].name, "_val"}, b, tab[i].val);
      if (i > 0) chk({tab[i].name, "_gap"}, 32'(t - pt), tab[i].gap);
      pt = t;
      if (i == 7) chk("init_done_before_clr_wait", init_done, 0);
    end
    chk("init_done_after_clr_wait", init_done, 1);
    last_t = t;
  endtask

  task automatic frame(input logic [255:0] exp, input logic [255:0] nxt);
    logic rs;
    logic [7:0] b;
    int t;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) begin
        get_byte(rs, b, t);
        chk("addr2_rs", rs, 0);
        chk("addr2_cmd", b, 8'hC0);
        chk("addr2_gap", 32'(t - last_t), 16);
        last_t = t;
      end
      get_byte(rs, b, t);
      chk($sformatf("char%0d_rs", i), rs, 1);
      chk($sformatf("char%0d_val", i), b, exp[255 - 8 * i -: 8]);
      chk($sformatf("char%0d_gap", i), 32'(t - last_t), 16);
      last_t = t;
      if (i == 3) strdata = nxt;
    end
  endtask

  task automatic next_addr1(input int fd_exp);
    logic rs;
    logic [7:0] b;
    int t;
    chk("frame_done_before_addr1", fd_cnt, fd_exp - 1);
    get_byte(rs, b, t);
    chk("addr1_rs", rs, 0);
    chk("addr1_cmd", b, 8'h80);
    chk("addr1_gap", 32'(t - last_t), 16);
    last_t = t;
    chk("frame_done_count", fd_cnt, fd_exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    tab[0] = '{"init_nib0", 1'b1, 1'b0, 8'h03, 0};
    tab[1] = '{"init_nib1", 1'b1, 1'b0, 8'h03, 15};
    tab[2] = '{"init_nib2", 1'b1, 1'b0, 8'h03, 11};
    tab[3] = '{"init_nib3", 1'b1, 1'b0, 8'h02, 9};
    tab[4] = '{"cfg_func_set", 1'b0, 1'b0, 8'h28, 9};
    tab[5] = '{"cfg_entry", 1'b0, 1'b0, 8'h06, 16};
    tab[6] = '{"cfg_disp_on", 1'b0, 1'b0, 8'h0C, 16};
    tab[7] = '{"cfg_clear", 1'b0, 1'b0, 8'h01, 16};
    tab[8] = '{"addr1_first", 1'b0, 1'b0, 8'h80, 20};
    #1 RSTN = 1'b0;
    repeat (3) @(negedge CCLK);
    chk("rst_lcde", LCDE, 0);
    chk("rst_lcdrs", LCDRS, 0);
    chk("rst_lcddat", LCDDAT, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_done", frame_done, 0);
    RSTN = 1'b1;
    quiet_after_reset();
    run_init();
    frame(S1, S1);
    next_addr1(1);
    frame(S1, S2);
    next_addr1(2);
    frame(S2, S2);
    chk("frame_done_total", fd_cnt, 2);
    begin
      int k = 0;
      while (LCDE !== 1'b1 && k < 200) begin
        @(posedge CCLK);
        #1;
        k++;
      end
      chk("e_high_before_abort", LCDE, 1);
    end
    #1 RSTN = 1'b0;
    #1;
    chk("abort_lcde", LCDE, 0);
    chk("abort_lcdrs", LCDRS, 0);
    chk("abort_lcddat", LCDDAT, 0);
    chk("abort_init_done", init_done, 0);
    repeat (2) @(negedge CCLK);
    nq.delete();
    RSTN = 1'b1;
    quiet_after_reset();
    run_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lcd_string_driver.md
# lcd_string_driver

Drives the 16x2 character LCD (HD44780-compatible, 4-bit bus) from the 256-bit `strdata` bus produced by the CPU top-level debug/display logic. After reset it runs the power-on initialisation sequence, then refreshes both display lines continuously. Each frame uses a snapshot of `strdata` taken at frame start, so a half-updated string is never shown. It sits downstream of the pipeline CPU's display-string formatter and owns the board LCD pins.

## Interface
Parameters (default values are in CCLK cycles at 50 MHz; benches override them with small values):
- `T_PWR`, 750000: power-on wait, 15 ms
- `T_4MS`, 205000: wait after the first init nibble
- `T_100US`, 5000: wait after the second init nibble
- `T_40US`, 2000: wait after every other byte or init nibble
- `T_CLR`, 82000: wait after the clear-display command, 1.64 ms
- `T_1US`, 50: gap between the high and low nibble of one byte
- `T_SU`, 2: RS/DAT setup before E rises
- `T_EH`, 12: E high width

Ports:
- `CCLK`, in, 1: system clock.
- `RSTN`, in, 1: asynchronous, active-low reset.
- `strdata`, in, 256: 32 ASCII characters. Bits [255:248] are line 1, column 0. Bits [135:128] are line 1, column 15. Bits [127:120] are line 2, column 0. Bits [7:0] are line 2, column 15.
- `LCDE`, out, 1: LCD enable strobe.
- `LCDRS`, out, 1: register select. 0 means command, 1 means data.
- `LCDRW`, out, 1: read/write select. Tied to 0 (write only).
- `LCDDAT`, out, 4: data nibble.
- `init_done`, out, 1: goes high and stays high once configuration completes.
- `frame_done`, out, 1: one-cycle pulse after the last character of line 2 is written.

## Operation
- Reset (asynchronous on `RSTN` low) sets every output to 0, clears all counters, and sends the top FSM to PWR_WAIT. `RSTN` low in the middle of a byte write aborts it: `LCDE` drops in the same instant.
- Top FSM states and transitions:
  - PWR_WAIT: wait `T_PWR` cycles.
  - INIT: write four single nibbles, with RS=0 throughout:
    - 0x3, then wait `T_4MS`
    - 0x3, then wait `T_100US`
    - 0x3, then wait `T_40US`
    - 0x2, then wait `T_40US`
  - CFG: write four full bytes, with RS=0:
    - 0x28, then wait `T_40US`
    - 0x06, then wait `T_40US`
    - 0x0C, then wait `T_40US`
    - 0x01, then wait `T_CLR`
  - After CFG, `init_done` is set to 1.
  - ADDR1: command 0x80. The 256-bit snapshot register is loaded from `strdata` in the same cycle this state is entered.
  - LINE1: 16 data bytes, RS=1, columns 0 to 15.
  - ADDR2: command 0xC0.
  - LINE2: 16 data bytes, RS=1.
  - After LINE2: pulse `frame_done`, then go to ADDR1.
- Byte write: high nibble first, then a `T_1US` gap, then the low nibble, then the post-byte wait.
- Character index: a 5-bit counter. Character i is `snap[255-8i -: 8]`. The counter wraps 31 -> 0 at the end of each frame.
- Character codes are sent unmodified. 0x00 is written as-is.
- `strdata` changes during a frame have no effect until the next ADDR1.

## Timing
- Per nibble:
  - Cycle 0: `LCDRS` and `LCDDAT` are driven.
  - `LCDE` goes high after `T_SU` cycles and stays high for `T_EH` cycles.
  - `LCDE` then falls. `LCDRS` and `LCDDAT` are held one more cycle.
  - The gap or wait counter starts after that hold cycle.
- Per byte: `2*(T_SU+T_EH+1) + T_1US + post_wait` cycles.
- `LCDE` is never high while `LCDDAT` or `LCDRS` changes.
- `LCDE` is never high for more than `T_EH` consecutive cycles.
- A wait parameter of 0 is legal and means no wait cycles.
- All outputs are registered. No combinational path exists from `strdata` to the pins.

## Structure
- Package `lcd_pkg`:
  - Command constants: `LCD_FUNC_SET`=0x28, `LCD_ENTRY`=0x06, `LCD_DISP_ON`=0x0C, `LCD_CLEAR`=0x01, `LCD_LINE1`=0x80, `LCD_LINE2`=0xC0.
  - Top-FSM state enum.
- Sub-module `lcd_nibble_writer` (inputs: `start`, `rs`, `nib`, `wait_cycles`; outputs: `done`, pins). It owns the setup, E-high, hold and wait counters.
- The top module holds the sequencer FSM, the snapshot register and the character counter.

## Test plan
All scenarios use small parameters: `T_PWR`=20, `T_4MS`=10, `T_100US`=6, `T_40US`=4, `T_CLR`=8, `T_1US`=2, `T_SU`=1, `T_EH`=3.
1. Reset release -> outputs stay 0 for 20 cycles. The first `LCDE` pulse then carries `LCDDAT`=0x3 with `LCDRS`=0, and the first four E pulses carry 0x3, 0x3, 0x3, 0x2.
2. Init completes -> decoded command bytes are 0x28, 0x06, 0x0C, 0x01, followed by 0x80. `init_done` rises after the 0x01 wait.
3. `strdata` = "Hello..." pattern -> a bus monitor decodes, in order: 0x80; 16 bytes equal to `strdata[255:128]` with RS=1; 0xC0; 16 bytes equal to `strdata[127:0]`. Then exactly one `frame_done` pulse.
4. `strdata` changed in the middle of LINE1 -> the current frame shows the old string. The next frame shows the new one.
5. `RSTN` pulsed low while `LCDE`=1 -> `LCDE`, `LCDRS`, `LCDDAT`, `init_done` are 0 immediately. The full init sequence is repeated.
6. Protocol checker over 3 frames -> no `LCDDAT`/`LCDRS` change while `LCDE`=1, every E-high run is exactly 3 cycles, and `LCDRW` is always 0.
